// File: rtl/dl11_uart_ctl_if.sv
// ----------------------------------------------------------------------------
// dl11_uart_ctl_if
// Single-clock register bus between a CPU-side master and the DL11 console
// register file.
//   bus_addr     : word select (0=RCSR, 1=RBUF, 2=XCSR, 3=XBUF)
//   bus_rd       : one-cycle read strobe
//   bus_wr       : one-cycle write strobe (word writes only)
//   bus_data_in  : write data
//   bus_data_out : registered read data, valid with bus_ack
//   bus_ack      : one-cycle acknowledge, one cycle after the strobe
// ----------------------------------------------------------------------------
interface dl11_uart_ctl_if;
    logic [1:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_data_in;
    logic [15:0] bus_data_out;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_rd, bus_wr, bus_data_in,
        input  bus_data_out, bus_ack
    );

    modport slave (
        input  bus_addr, bus_rd, bus_wr, bus_data_in,
        output bus_data_out, bus_ack
    );
endinterface

// File: rtl/dl11_uart_ctl.sv
// ----------------------------------------------------------------------------
// dl11_uart_ctl
// Host-side controller for a uart: DL11-style console registers (RCSR, RBUF,
// XCSR, XBUF) with ready/done flags, overrun capture and interrupt requests,
// driving the uart parallel load/unload handshake.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   bus               : register bus (slave side of dl11_uart_ctl_if)
//   rx_irq/rx_irq_ack : receiver interrupt request / acknowledge
//   tx_irq/tx_irq_ack : transmitter interrupt request / acknowledge
//   uart_ld_tx_data   : load request to uart transmitter
//   uart_tx_data      : transmit byte
//   uart_tx_empty     : uart transmitter idle (txclk domain, synchronized here)
//   uart_uld_rx_data  : unload request to uart receiver
//   uart_rx_data      : uart receive byte
//   uart_rx_empty     : uart receiver empty (rxclk domain, synchronized here)
// ----------------------------------------------------------------------------
module dl11_uart_ctl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    dl11_uart_ctl_if.slave bus,
    output logic        rx_irq,
    input  logic        rx_irq_ack,
    output logic        tx_irq,
    input  logic        tx_irq_ack,
    output logic        uart_ld_tx_data,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_empty,
    output logic        uart_uld_rx_data,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_empty
);

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_UNLD}          rx_state_t;

    tx_state_t r_tx_state, w_tx_next;
    rx_state_t r_rx_state, w_rx_next;

    logic [SYNC_STAGES-1:0] r_tx_sync;
    logic [SYNC_STAGES-1:0] r_rx_sync;
    logic                   w_tx_empty;
    logic                   w_rx_empty;

    logic        r_rdone, r_rie, r_ovr, r_xrdy, r_tie;
    logic [7:0]  r_rbuf;
    logic [7:0]  r_tx_data;
    logic [15:0] r_data_out;
    logic        r_ack;
    logic        r_rx_irq, r_tx_irq;
    logic        r_rx_cond_d, r_tx_cond_d;

    logic        w_rd, w_wr, w_rbuf_rd, w_tx_start;
    logic        w_tx_done, w_capture, w_ld, w_uld;
    logic        w_rx_cond, w_tx_cond;
    logic [15:0] w_rd_data;
    logic        w_unused_din;

    assign w_unused_din = ^{bus.bus_data_in[15:8], bus.bus_data_in[5:0]};

    // ------------------------------------------------------------------
    // Synchronizers for the uart-domain status lines, preset to idle/empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_sync <= '1;
            r_rx_sync <= '1;
        end else begin
            r_tx_sync <= {r_tx_sync[SYNC_STAGES-2:0], uart_tx_empty};
            r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], uart_rx_empty};
        end
    end

    assign w_tx_empty = r_tx_sync[SYNC_STAGES-1];
    assign w_rx_empty = r_rx_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Bus decode: rd and wr together is a read.
    // ------------------------------------------------------------------
    assign w_rd       = bus.bus_rd;
    assign w_wr       = bus.bus_wr & ~bus.bus_rd;
    assign w_rbuf_rd  = w_rd & (bus.bus_addr == 2'd1);
    assign w_tx_start = w_wr & (bus.bus_addr == 2'd3) & r_xrdy;

    always_comb begin
        w_rd_data = '0;
        case (bus.bus_addr)
            2'd0:    w_rd_data = {8'h00, r_rdone, r_rie, 6'h00};
            2'd1:    w_rd_data = {r_ovr, r_ovr, 6'h00, r_rbuf};
            2'd2:    w_rd_data = {8'h00, r_xrdy, r_tie, 6'h00};
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ack      <= bus.bus_rd | bus.bus_wr;
            r_data_out <= w_rd ? w_rd_data : '0;
        end
    end

    assign bus.bus_ack      = r_ack;
    assign bus.bus_data_out = r_data_out;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_ld      = 1'b0;
        w_tx_done = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (w_tx_start) w_tx_next = TX_LOAD;
            TX_LOAD: begin
                w_ld = 1'b1;
                if (!w_tx_empty) w_tx_next = TX_WAIT;
            end
            TX_WAIT: if (w_tx_empty) begin
                w_tx_next = TX_IDLE;
                w_tx_done = 1'b1;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    assign uart_ld_tx_data = w_ld;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_uld     = 1'b0;
        w_capture = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (!w_rx_empty) w_rx_next = RX_UNLD;
            RX_UNLD: begin
                w_uld = 1'b1;
                if (w_rx_empty) begin
                    w_rx_next = RX_IDLE;
                    w_capture = 1'b1;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    assign uart_uld_rx_data = w_uld;

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdone   <= 1'b0;
            r_rie     <= 1'b0;
            r_ovr     <= 1'b0;
            r_rbuf    <= '0;
            r_xrdy    <= 1'b1;
            r_tie     <= 1'b0;
            r_tx_data <= '0;
        end else begin
            // A capture coinciding with an RBUF read wins; the read has
            // already consumed the old byte, so no overrun is recorded.
            if (w_capture) begin
                r_rbuf  <= uart_rx_data;
                r_rdone <= 1'b1;
                r_ovr   <= w_rbuf_rd ? 1'b0 : (r_ovr | r_rdone);
            end else if (w_rbuf_rd) begin
                r_rdone <= 1'b0;
                r_ovr   <= 1'b0;
            end

            if (w_wr && bus.bus_addr == 2'd0) r_rie <= bus.bus_data_in[6];
            if (w_wr && bus.bus_addr == 2'd2) r_tie <= bus.bus_data_in[6];

            if (w_tx_done) begin
                r_xrdy <= 1'b1;
            end else if (w_tx_start) begin
                r_xrdy    <= 1'b0;
                r_tx_data <= bus.bus_data_in[7:0];
            end
        end
    end

    assign uart_tx_data = r_tx_data;

    // ------------------------------------------------------------------
    // Interrupts: set on rising edge of (flag & enable), clear on ack or
    // when the condition falls; ack beats a same-cycle set.
    // ------------------------------------------------------------------
    assign w_rx_cond = r_rdone & r_rie;
    assign w_tx_cond = r_xrdy & r_tie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_cond_d <= 1'b0;
            r_tx_cond_d <= 1'b0;
            r_rx_irq    <= 1'b0;
            r_tx_irq    <= 1'b0;
        end else begin
            r_rx_cond_d <= w_rx_cond;
            r_tx_cond_d <= w_tx_cond;

            if (rx_irq_ack)                     r_rx_irq <= 1'b0;
            else if (w_rx_cond && !r_rx_cond_d) r_rx_irq <= 1'b1;
            else if (!w_rx_cond)                r_rx_irq <= 1'b0;

            if (tx_irq_ack)                     r_tx_irq <= 1'b0;
            else if (w_tx_cond && !r_tx_cond_d) r_tx_irq <= 1'b1;
            else if (!w_tx_cond)                r_tx_irq <= 1'b0;
        end
    end

    assign rx_irq = r_rx_irq;
    assign tx_irq = r_tx_irq;

endmodule

// File: tb/tb_dl11_uart_ctl.sv
// ----------------------------------------------------------------------------
// tb_dl11_uart_ctl
// Self-checking bench for dl11_uart_ctl with behavioural uart models on both
// the transmit and receive handshakes. Bus read results are predicted when
// the strobe is issued and compared when bus_ack appears.
// ----------------------------------------------------------------------------
module tb_dl11_uart_ctl;

    localparam int TX_BUSY = 20;

    logic       clk;
    logic       reset;
    logic       rx_irq, rx_irq_ack, tx_irq, tx_irq_ack;
    logic       uart_ld_tx_data, uart_uld_rx_data;
    logic [7:0] uart_tx_data, uart_rx_data;
    logic       uart_tx_empty, uart_rx_empty;

    dl11_uart_ctl_if bif ();

    dl11_uart_ctl #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bif.slave),
        .rx_irq           (rx_irq),
        .rx_irq_ack       (rx_irq_ack),
        .tx_irq           (tx_irq),
        .tx_irq_ack       (tx_irq_ack),
        .uart_ld_tx_data  (uart_ld_tx_data),
        .uart_tx_data     (uart_tx_data),
        .uart_tx_empty    (uart_tx_empty),
        .uart_uld_rx_data (uart_uld_rx_data),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_empty    (uart_rx_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ld     = 0;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];
    sb_t sb_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ack pops one pending transaction; reads compare data.
    always @(negedge clk) begin
        if (!reset && bif.bus_ack) begin
            chk("ack_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                if (sb_e.is_rd) chk("rd_data", 32'(bif.bus_data_out), 32'(sb_e.exp));
            end
        end
    end

    // Transmit-side uart model: accepts a load, goes busy, then idle.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_ld_tx_data && uart_tx_empty) begin
                n_ld++;
                repeat (3) @(posedge clk);
                #1 uart_tx_empty = 1'b0;
                repeat (TX_BUSY) @(posedge clk);
                #1 uart_tx_empty = 1'b1;
            end
        end
    end

    task automatic bus_xfer(input logic rd, input logic wr, input logic [1:0] a,
                            input logic [15:0] d, input logic [15:0] exp);
        @(posedge clk); #1;
        bif.bus_addr    = a;
        bif.bus_rd      = rd;
        bif.bus_wr      = wr;
        bif.bus_data_in = d;
        sb_q.push_back(sb_t'{is_rd: rd, exp: exp});
        @(posedge clk); #1;
        bif.bus_rd = 1'b0;
        bif.bus_wr = 1'b0;
        chk("ack_latency", 32'(bif.bus_ack), 32'd1);
        @(posedge clk); #1;
        chk("ack_single", 32'(bif.bus_ack), 32'd0);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [15:0] exp);
        bus_xfer(1'b1, 1'b0, a, 16'h0000, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_xfer(1'b0, 1'b1, a, d, 16'h0000);
    endtask

    // Receive-side uart model: present a byte, wait for unload, go empty.
    // Returns #1 after the edge at which rx_empty was raised.
    task automatic rx_present(input logic [7:0] b);
        bit ok;
        @(posedge clk); #1;
        uart_rx_data  = b;
        uart_rx_empty = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_uld_rx_data) begin
                ok = 1'b1;
                break;
            end
        end
        chk("uld_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        uart_rx_empty = 1'b1;
    endtask

    task automatic rx_deliver(input logic [7:0] b);
        rx_present(b);
        repeat (4) @(posedge clk);
        #1;
        chk("uld_dropped", 32'(uart_uld_rx_data), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset           = 1'b1;
        rx_irq_ack      = 1'b0;
        tx_irq_ack      = 1'b0;
        uart_tx_empty   = 1'b1;
        uart_rx_empty   = 1'b1;
        uart_rx_data    = 8'h00;
        bif.bus_addr    = 2'd0;
        bif.bus_rd      = 1'b0;
        bif.bus_wr      = 1'b0;
        bif.bus_data_in = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(bif.bus_data_out), 32'h0);
        chk("rst_ack", 32'(bif.bus_ack), 32'h0);
        chk("rst_irqs", 32'({rx_irq, tx_irq}), 32'h0);
        chk("rst_ld_uld", 32'({uart_ld_tx_data, uart_uld_rx_data}), 32'h0);
        chk("rst_tx_data", 32'(uart_tx_data), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset register values
        bus_read(2'd2, 16'h0080);
        bus_read(2'd0, 16'h0000);
        bus_read(2'd1, 16'h0000);
        bus_read(2'd3, 16'h0000);

        // rd+wr together acts as a read: TIE must not be set
        bus_xfer(1'b1, 1'b1, 2'd2, 16'h0040, 16'h0080);
        bus_read(2'd2, 16'h0080);
        chk("rdwr_no_tx_irq", 32'(tx_irq), 32'h0);

        // Transmit one byte
        bus_write(2'd3, 16'hFF41);
        chk("ld_asserted", 32'(uart_ld_tx_data), 32'd1);
        chk("tx_data", 32'(uart_tx_data), 32'h41);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!uart_tx_empty) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tx_empty_fell", 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("ld_held_through_sync", 32'(uart_ld_tx_data), 32'd1);
        @(posedge clk); #1;
        chk("ld_dropped", 32'(uart_ld_tx_data), 32'd0);
        bus_read(2'd2, 16'h0000);
        bus_write(2'd3, 16'h0042);
        bus_read(2'd2, 16'h0000);
        chk("tx_data_kept", 32'(uart_tx_data), 32'h41);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (uart_tx_empty) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tx_empty_rose", 32'(ok), 32'd1);
        repeat (4) @(posedge clk);
        bus_read(2'd2, 16'h0080);
        chk("one_ld_handshake", 32'(n_ld), 32'd1);
        chk("tx_data_final", 32'(uart_tx_data), 32'h41);

        // Receive one byte
        rx_deliver(8'h5A);
        bus_read(2'd0, 16'h0080);
        bus_read(2'd1, 16'h005A);
        bus_read(2'd0, 16'h0000);

        // Overrun
        rx_deliver(8'h11);
        rx_deliver(8'h22);
        bus_read(2'd1, 16'hC022);
        bus_read(2'd0, 16'h0000);
        bus_read(2'd1, 16'h0022);

        // RBUF read in the same cycle as a capture: capture wins
        rx_deliver(8'h33);
        rx_present(8'h44);
        @(posedge clk);
        bus_read(2'd1, 16'h0033);
        bus_read(2'd0, 16'h0080);
        bus_read(2'd1, 16'h0044);
        bus_read(2'd0, 16'h0000);

        // Receive interrupt timing and ack
        bus_write(2'd0, 16'h0040);
        chk("rx_irq_idle", 32'(rx_irq), 32'd0);
        rx_present(8'h55);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rx_irq_not_yet", 32'(rx_irq), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rx_irq_set", 32'(rx_irq), 32'd1);
        @(posedge clk); #1;
        rx_irq_ack = 1'b1;
        @(posedge clk); #1;
        rx_irq_ack = 1'b0;
        chk("rx_irq_acked", 32'(rx_irq), 32'd0);
        @(posedge clk); #1;
        chk("rx_irq_stays_clear", 32'(rx_irq), 32'd0);
        bus_read(2'd0, 16'h00C0);

        // Transmit interrupt when TIE set while idle
        bus_write(2'd2, 16'h0040);
        chk("tx_irq_set", 32'(tx_irq), 32'd1);
        bus_read(2'd2, 16'h00C0);

        // Async reset in the middle of a TX load
        bus_read(2'd1, 16'h0055);
        rx_deliver(8'h66);
        repeat (2) @(posedge clk);
        #1;
        chk("rx_irq_pre_reset", 32'(rx_irq), 32'd1);
        bus_write(2'd3, 16'h0077);
        chk("ld_pre_reset", 32'(uart_ld_tx_data), 32'd1);
        chk("tx_irq_fell_busy", 32'(tx_irq), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_ld_drop", 32'(uart_ld_tx_data), 32'd0);
        chk("reset_rx_irq_drop", 32'(rx_irq), 32'd0);
        chk("reset_tx_data", 32'(uart_tx_data), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("post_reset_ld_idle", 32'(uart_ld_tx_data), 32'd0);
        bus_read(2'd2, 16'h0080);
        bus_read(2'd0, 16'h0000);
        bus_read(2'd1, 16'h0000);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
